// File: rtl/mac_pkg.sv
// Shared widths, frame limit and FSM state encoding for the MAC accumulator.
package mac_pkg;

  localparam int PROD_W    = 16;
  localparam int ACC_W     = 24;
  localparam int CNT_W     = 5;
  localparam int MAX_TERMS = 16;

  localparam logic ST_ACCUM = 1'b0;
  localparam logic ST_DONE  = 1'b1;

  typedef enum logic {
    ACCUM = ST_ACCUM,
    DONE  = ST_DONE
  } state_t;

endpackage

// File: rtl/mac_accumulator_if.sv
// Term input and result output handshakes of the MAC accumulator.
interface mac_accumulator_if #(
  parameter int PROD_W = mac_pkg::PROD_W,
  parameter int ACC_W  = mac_pkg::ACC_W,
  parameter int CNT_W  = mac_pkg::CNT_W
);

  logic [PROD_W-1:0] prod_in;
  logic              in_valid;
  logic              in_last;
  logic              in_ready;
  logic [ACC_W-1:0]  acc_out;
  logic [CNT_W-1:0]  term_cnt;
  logic              ovf;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output prod_in, in_valid, in_last, out_ready,
    input  in_ready, acc_out, term_cnt, ovf, out_valid
  );

  modport slave (
    input  prod_in, in_valid, in_last, out_ready,
    output in_ready, acc_out, term_cnt, ovf, out_valid
  );

endinterface

// File: rtl/mac_sat_add.sv
// ACC_W-bit adder with carry-out; clamps to all-ones when MAC_ACC_SATURATE_EN is defined,
// otherwise wraps modulo 2^ACC_W.
module mac_sat_add #(
  parameter int ACC_W = mac_pkg::ACC_W
) (
  input  logic [ACC_W-1:0] a,
  input  logic [ACC_W-1:0] b,
  output logic [ACC_W-1:0] sum,
  output logic             carry
);

  logic [ACC_W-1:0] raw;

  always_comb begin
    {carry, raw} = {1'b0, a} + {1'b0, b};
`ifdef MAC_ACC_SATURATE_EN
    sum = carry ? '1 : raw;
`else
    sum = raw;
`endif
  end

endmodule

// File: rtl/mac_accumulator.sv
// Frame-based multiply-accumulate back end: sums product terms until in_last or MAX_TERMS,
// then holds the result for the consumer. Saturating add selected by MAC_ACC_SATURATE_EN.
//
// state | meaning
// ACCUM | accepting terms, building the frame sum
// DONE  | result presented, waiting for out_ready
module mac_accumulator #(
  parameter int PROD_W    = mac_pkg::PROD_W,
  parameter int ACC_W     = mac_pkg::ACC_W,
  parameter int MAX_TERMS = mac_pkg::MAX_TERMS,
  parameter int CNT_W     = mac_pkg::CNT_W
) (
  input logic               clk,
  input logic               rst,
  mac_accumulator_if.slave  bus
);

  import mac_pkg::*;

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] count;
  logic             sticky_ovf;

  logic [ACC_W-1:0] acc_out_q;
  logic [CNT_W-1:0] term_cnt_q;
  logic             ovf_q;
  logic             out_valid_q;
  logic             in_ready_q;

  logic [ACC_W-1:0] sum;
  logic             carry;
  logic             accept;
  logic             close;

  mac_sat_add #(.ACC_W(ACC_W)) u_add (
    .a     (acc),
    .b     (ACC_W'(bus.prod_in)),
    .sum   (sum),
    .carry (carry)
  );

  // in_ready_q is only high in ACCUM, so it doubles as the state qualifier
  assign accept = bus.in_valid & in_ready_q;
  assign close  = bus.in_last | (count == CNT_W'(MAX_TERMS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ACCUM;
      acc         <= '0;
      count       <= '0;
      sticky_ovf  <= 1'b0;
      acc_out_q   <= '0;
      term_cnt_q  <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      case (state)
        ACCUM: begin
          if (accept) begin
            acc        <= sum;
            count      <= count + CNT_W'(1);
            sticky_ovf <= sticky_ovf | carry;
            if (close) begin
              acc_out_q   <= sum;
              term_cnt_q  <= count + CNT_W'(1);
              ovf_q       <= sticky_ovf | carry;
              out_valid_q <= 1'b1;
              in_ready_q  <= 1'b0;
              state       <= DONE;
            end
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            acc         <= '0;
            count       <= '0;
            sticky_ovf  <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= ACCUM;
          end
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.acc_out   = acc_out_q;
  assign bus.term_cnt  = term_cnt_q;
  assign bus.ovf       = ovf_q;

endmodule
